// File: rtl/qtable_wb_ctrl.sv
// Q-table write-back controller.
// Write-back triples pass through a two-stage pending queue (S1, S2) so that they
// reach the RAM two cycles after they are accepted.
// Reads are served from the RAM. A read is served instead from an in-flight write
// when it targets one; the youngest matching write is used.
// Malformed one-hot actions are dropped and counted in a saturating counter.
module qtable_wb_ctrl #(
  parameter int SW = 6,
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  input  logic [SW-1:0]   wr_state,
  input  logic [AW-1:0]   wr_action,
  input  logic [DW-1:0]   wr_q,
  input  logic            rd_en,
  input  logic [SW-1:0]   rd_state,
  input  logic [AW-1:0]   rd_action,
  output logic [SW+1:0]   ram_raddr,
  input  logic [DW-1:0]   ram_rdata,
  output logic            ram_we,
  output logic [SW+1:0]   ram_waddr,
  output logic [DW-1:0]   ram_wdata,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_q,
  output logic [7:0]      err_cnt
);

  localparam int RAW = SW + 2;

  // Converts a one-hot action into its 2-bit table column.
  // An invalid action is rejected elsewhere, so the value returned for it does not matter.
  function automatic logic [1:0] act_idx(input logic [AW-1:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < AW; i++) begin
      if (a[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  logic           s1_vld_q, s1_vld_d;
  logic [RAW-1:0] s1_addr_q, s1_addr_d;
  logic [DW-1:0]  s1_data_q, s1_data_d;
  logic           s2_vld_q, s2_vld_d;
  logic [RAW-1:0] s2_addr_q, s2_addr_d;
  logic [DW-1:0]  s2_data_q, s2_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           fwd_q, fwd_d;
  logic [DW-1:0]  fwd_data_q, fwd_data_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic           wr_ok, rd_ok, wr_acc;
  logic [RAW-1:0] wr_addr, rd_addr;
  logic [1:0]     err_inc;
  logic [8:0]     err_sum;

  // Decode the requests, advance the pending queue, pick the forward source
  // and update the error count.
  always_comb begin
    wr_ok      = $onehot(wr_action);
    rd_ok      = $onehot(rd_action);
    wr_addr    = {wr_state, act_idx(wr_action)};
    rd_addr    = {rd_state, act_idx(rd_action)};
    wr_acc     = wr_valid & wr_ok;

    s1_vld_d   = wr_acc;
    s1_addr_d  = wr_addr;
    s1_data_d  = wr_q;
    s2_vld_d   = s1_vld_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = s1_data_q;

    // The youngest matching write wins.
    // S2 must still be checked: the RAM returns the old value while S2 is being written.
    // A malformed read is forced to forward zero.
    rd_valid_d = rd_en;
    fwd_d      = 1'b0;
    fwd_data_d = '0;
    if (rd_en) begin
      if (!rd_ok) begin
        fwd_d      = 1'b1;
        fwd_data_d = '0;
      end else if (wr_acc && (wr_addr == rd_addr)) begin
        fwd_d      = 1'b1;
        fwd_data_d = wr_q;
      end else if (s1_vld_q && (s1_addr_q == rd_addr)) begin
        fwd_d      = 1'b1;
        fwd_data_d = s1_data_q;
      end else if (s2_vld_q && (s2_addr_q == rd_addr)) begin
        fwd_d      = 1'b1;
        fwd_data_d = s2_data_q;
      end
    end

    err_inc    = {1'b0, wr_valid & ~wr_ok} + {1'b0, rd_en & ~rd_ok};
    err_sum    = {1'b0, err_cnt_q} + {7'd0, err_inc};
    err_cnt_d  = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // Register the state. Reset discards any pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      rd_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_vld_q   <= s2_vld_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
      rd_valid_q <= rd_valid_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ram_raddr = rd_addr;
  assign ram_we    = s2_vld_q;
  assign ram_waddr = s2_addr_q;
  assign ram_wdata = s2_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_q      = !rd_valid_q ? '0 : (fwd_q ? fwd_data_q : ram_rdata);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_qtable_wb_ctrl.sv
// Testbench for qtable_wb_ctrl.
// The bench provides a RAM with a one-cycle registered read. A read and a write
// to the same address in one cycle return the old data.
module tb_qtable_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_state = '0;
  logic [3:0]  wr_action = '0;
  logic [15:0] wr_q = '0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_state = '0;
  logic [3:0]  rd_action = '0;
  logic [7:0]  ram_raddr;
  logic [15:0] ram_rdata = '0;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        rd_valid;
  logic [15:0] rd_q;
  logic [7:0]  err_cnt;

  logic        mem_clr = 1'b1;
  logic [15:0] mem [0:255];

  int total = 0;
  int bad = 0;

  qtable_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_state(wr_state), .wr_action(wr_action), .wr_q(wr_q),
    .rd_en(rd_en), .rd_state(rd_state), .rd_action(rd_action),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .rd_valid(rd_valid), .rd_q(rd_q), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: the read is registered and sees the contents before any write in the same edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_raddr];
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, total=%0d", total);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wv; logic [5:0] ws; logic [3:0] wa; logic [15:0] wq;
    logic        re; logic [5:0] rs; logic [3:0] ra;
    logic        e_we; logic [7:0] e_waddr; logic [15:0] e_wdata;
    logic        e_rv; logic [15:0] e_rq;
  } vec_t;

  function automatic vec_t mk(int wv, int ws, int wa, int wq, int re, int rs, int ra,
                              int ew, int ea, int ed, int ev, int eq);
    vec_t v;
    v.wv = wv[0]; v.ws = ws[5:0]; v.wa = wa[3:0]; v.wq = wq[15:0];
    v.re = re[0]; v.rs = rs[5:0]; v.ra = ra[3:0];
    v.e_we = ew[0]; v.e_waddr = ea[7:0]; v.e_wdata = ed[15:0];
    v.e_rv = ev[0]; v.e_rq = eq[15:0];
    return v;
  endfunction

  // Table address = {state, column}. Columns 0..3 correspond to one-hot actions 0001, 0010, 0100, 1000.
  function automatic logic [7:0] ref_addr(input logic [5:0] s, input logic [3:0] a);
    int col;
    col = 0;
    case (a)
      4'b0001: col = 0;
      4'b0010: col = 1;
      4'b0100: col = 2;
      4'b1000: col = 3;
      default: col = 0;
    endcase
    return {s, 2'(col)};
  endfunction

  function automatic logic [3:0] pick_action();
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  task automatic drive_idle();
    wr_valid = 1'b0; rd_en = 1'b0;
    wr_state = '0; wr_action = '0; wr_q = '0;
    rd_state = '0; rd_action = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0; mem_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
  endtask

  task automatic bad_pair();
    @(negedge clk);
    wr_valid = 1'b1; wr_state = 6'd1; wr_action = 4'b0000; wr_q = 16'h5555;
    rd_en = 1'b1; rd_state = 6'd1; rd_action = 4'b0011;
  endtask

  vec_t vecs[$];
  logic [15:0] model [0:255];
  int merr;
  logic exp_rv;
  logic [15:0] exp_rq;

  initial begin
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_q", 32'(rd_q), 32'd0);
    chk("reset ram_waddr", 32'(ram_waddr), 32'd0);
    chk("reset ram_wdata", 32'(ram_wdata), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1; mem_clr = 1'b0;

    // Directed per-cycle vectors: each row gives the inputs for one cycle and the outputs expected in that cycle.
    vecs.push_back(mk(1, 5, 1, 'h0123, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h14, 'h0123, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 4, 'h7FFF, 1, 3, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4, 0, 0, 0, 1, 'h7FFF));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4, 1, 'h0E, 'h7FFF, 1, 'h7FFF));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 4, 0, 0, 0, 1, 'h7FFF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h7FFF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 4, 'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 4, 'hFFFF, 1, 3, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h0E, 'h0001, 1, 'hFFFF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h0E, 'hFFFF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 9, 8, 'h0AAA, 1, 3, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hFFFF));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h27, 'h0AAA, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_valid = vecs[i].wv; wr_state = vecs[i].ws; wr_action = vecs[i].wa; wr_q = vecs[i].wq;
      rd_en = vecs[i].re; rd_state = vecs[i].rs; rd_action = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d ram_waddr", i), 32'(ram_waddr), 32'(vecs[i].e_waddr));
        chk($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wdata));
      end
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d rd_q", i), 32'(rd_q), 32'(vecs[i].e_rq));
    end

    // Randomized traffic against the reference model.
    // A read returns the latest accepted write to its address; a write in the same cycle counts.
    do_reset();
    for (int a = 0; a < 256; a++) model[a] = '0;
    merr = 0; exp_rv = 1'b0; exp_rq = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic        wv, re, wok, rok;
      logic [5:0]  ws, rs;
      logic [3:0]  wa, ra;
      logic [15:0] wq;
      @(negedge clk);
      chk("rand rd_valid", 32'(rd_valid), 32'(exp_rv));
      if (exp_rv) chk("rand rd_q", 32'(rd_q), 32'(exp_rq));
      chk("rand err_cnt", 32'(err_cnt), 32'(merr));
      wv = 1'($urandom_range(0, 1)); ws = 6'($urandom_range(0, 3)); wa = pick_action(); wq = 16'($urandom);
      re = 1'($urandom_range(0, 1)); rs = 6'($urandom_range(0, 3)); ra = pick_action();
      wr_valid = wv; wr_state = ws; wr_action = wa; wr_q = wq;
      rd_en = re; rd_state = rs; rd_action = ra;
      wok = ($countones(wa) == 1);
      rok = ($countones(ra) == 1);
      #1;
      if (re && rok) chk("rand ram_raddr", 32'(ram_raddr), 32'(ref_addr(rs, ra)));
      merr = merr + ((wv && !wok) ? 1 : 0) + ((re && !rok) ? 1 : 0);
      if (merr > 255) merr = 255;
      if (wv && wok) model[ref_addr(ws, wa)] = wq;
      exp_rv = re;
      exp_rq = rok ? model[ref_addr(rs, ra)] : 16'h0000;
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("rand last rd_valid", 32'(rd_valid), 32'(exp_rv));
    if (exp_rv) chk("rand last rd_q", 32'(rd_q), 32'(exp_rq));
    chk("rand last err_cnt", 32'(err_cnt), 32'(merr));

    // Malformed write and read in the same cycle, then saturation of the error count.
    do_reset();
    bad_pair();
    @(negedge clk);
    drive_idle();
    #1;
    chk("bad rd_valid", 32'(rd_valid), 32'd1);
    chk("bad rd_q", 32'(rd_q), 32'd0);
    chk("bad err_cnt", 32'(err_cnt), 32'd2);
    chk("bad ram_we t+1", 32'(ram_we), 32'd0);
    @(negedge clk);
    #1;
    chk("bad ram_we t+2", 32'(ram_we), 32'd0);
    chk("bad rd_valid single", 32'(rd_valid), 32'd0);
    for (int k = 0; k < 126; k++) bad_pair();
    @(negedge clk);
    drive_idle();
    #1;
    chk("err_cnt 254", 32'(err_cnt), 32'd254);
    bad_pair();
    @(negedge clk);
    drive_idle();
    #1;
    chk("err_cnt sat from 254", 32'(err_cnt), 32'd255);
    for (int k = 0; k < 172; k++) bad_pair();
    @(negedge clk);
    drive_idle();
    #1;
    chk("err_cnt after 300", 32'(err_cnt), 32'd255);

    // Reset asserted while writes are still pending in the queue.
    do_reset();
    @(negedge clk);
    wr_valid = 1'b1; wr_state = 6'd7; wr_action = 4'b0001; wr_q = 16'h1111;
    rd_en = 1'b1; rd_state = 6'd7; rd_action = 4'b0001;
    @(negedge clk);
    wr_state = 6'd8; wr_q = 16'h2222; rd_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst rd_valid", 32'(rd_valid), 32'd0);
    chk("rst rd_q", 32'(rd_q), 32'd0);
    chk("rst ram_waddr", 32'(ram_waddr), 32'd0);
    chk("rst ram_wdata", 32'(ram_wdata), 32'd0);
    @(negedge clk);
    wr_state = 6'd9; wr_q = 16'h3333;
    #1;
    chk("rst hold ram_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst ram_we c%0d", k), 32'(ram_we), 32'd0);
      chk($sformatf("post-rst rd_valid c%0d", k), 32'(rd_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qtable_wb_ctrl.md
Name: qtable_wb_ctrl

Overview:
Far end of the Q-update pipeline. Accepts delayed (state, action, Q) write-back triples and commits them to the Q-table RAM through a 2-stage pending-write queue that matches the 2-cycle pipeline delay. It also serves Q-table reads. When a read targets a write that has not yet landed in RAM, the block forwards the in-flight value so the learning loop never sees a stale Q.

Parameters:
SW, 6, state index width
AW, 4, action width (one-hot, 4 actions)
DW, 16, Q value width (two's complement)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write-back request this cycle
wr_state  in  SW  write state index
wr_action  in  AW  write action, one-hot
wr_q  in  DW  updated Q value
rd_en  in  1  read request this cycle
rd_state  in  SW  read state index
rd_action  in  AW  read action, one-hot
ram_raddr  out  SW+2  RAM read address, combinational from rd_*
ram_rdata  in  DW  RAM read data, valid 1 cycle after address (read-old on same-address write)
ram_we  out  1  RAM write enable (registered)
ram_waddr  out  SW+2  RAM write address (registered)
ram_wdata  out  DW  RAM write data (registered)
rd_valid  out  1  rd_q valid this cycle
rd_q  out  DW  read result
err_cnt  out  8  count of malformed one-hot requests, saturating

Behaviour:
- Reset is async, active-low. It clears S1/S2 valid, ram_we, rd_valid, the forward flag and err_cnt. rd_q, ram_waddr and ram_wdata are 0 during reset.
- Address mapping: addr = {state, idx}. idx = 0..3 for action 4'b0001, 0010, 0100, 1000.
- A one-hot action is invalid when it is zero or has more than one bit set.
- Write path, request accepted in cycle t:
  - Valid action: S1 is loaded at the end of t, S2 at the end of t+1.
  - S2 drives ram_we=1, ram_waddr and ram_wdata during cycle t+2. The RAM commits at the end of t+2.
  - Back-to-back writes are accepted every cycle with no stall.
  - Invalid action: the write is dropped (S1 valid=0) and err_cnt increments.
- Read path, request issued in cycle r:
  - ram_raddr = addr(rd_*) during r.
  - rd_valid=1 and rd_q are presented in cycle r+1 only.
- Forwarding is decided in cycle r by comparing the read addr against three candidates, youngest wins:
  1. The incoming write in cycle r (wr_valid with a valid action): write-first semantics.
  2. S1.
  3. S2, which is being written in r; RAM returns the old value.
- The winning value and a forward flag are registered. In r+1, rd_q = forward ? fwd_data : ram_rdata.
- Invalid read action: rd_valid=1 in r+1, rd_q=0, err_cnt increments.
- err_cnt adds +1 per malformed wr or rd request and +2 when both are malformed in the same cycle. It saturates at 255 and clears only on reset.
- Simultaneous rd_en and wr_valid to different addresses proceed independently.
- Reset mid-operation discards pending writes. No RAM write issues after rst_n deasserts until a new request arrives.
- rd_valid is a single-cycle pulse per rd_en, with no buffering. Consecutive rd_en produce consecutive rd_valid.

Test Plan:
1. Write addr {5,0001} with Q=0x0123 at t=0 → ram_we=1, ram_waddr=0x14, ram_wdata=0x0123 at t=2; ram_we=0 at t=1 and t=3.
2. Write {3,0100}=0x7FFF at t=0; read the same address at t=0, t=1 and t=2 with RAM holding 0x0000 → rd_q=0x7FFF each following cycle (write-first, S1 hit, S2 hit). A read at t=3 returns ram_rdata.
3. Write {3,0100}=0x0001 at t=0 and 0xFFFF at t=1; read at t=1 → rd_q=0xFFFF (youngest wins over S1).
4. Write with wr_action=0000 and, in the same cycle, read with rd_action=0011 → no ram_we at t+2; rd_valid=1 with rd_q=0 at t+1; err_cnt=2. After 300 such pairs, err_cnt=255.
5. Issue 3 back-to-back writes, then pull rst_n low at t=1 → ram_we=0 immediately and stays 0 after release; rd_valid=0.
6. Random interleaved reads and writes against a behavioural RAM model → every rd_q equals the model's most recent accepted write to that address.
